// File: rtl/icache_refill_unit.sv
// I-cache line refill engine: fetches eight 32-bit words over a single-outstanding
// memory port and writes the line to the fetch cache port. Define ICACHE_REFILL_CWF_EN for critical-word-first.
`ifndef VLEN
`define VLEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module icache_refill_unit (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [`VLEN-1:2]     req_vaddr,
    input  logic [`XLEN-1:2]     req_paddr,
    input  logic                 abort,
    input  logic                 stall,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [`XLEN-1:2]     mem_req_addr,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_resp_data,
    input  logic                 mem_resp_error,
    output logic [`VLEN-1:5]     cache_port_addr,
    output logic [7:0][31:0]     cache_port_data,
    output logic                 cache_port_set,
    output logic                 done,
    output logic                 fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FAULT,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic [`VLEN-1:5]    r_line_vaddr;
    logic [`XLEN-1:5]    r_line_paddr;
    logic [2:0]          r_word_idx;
    logic [3:0]          r_beat_cnt;
    logic [7:0][31:0]    r_line_data;
    logic                r_req_ready;
    logic                r_mem_req_valid;
    logic                r_in_write;
    logic                r_in_fault;
    logic [2:0]          w_start_word;
    logic                w_unused;

`ifdef ICACHE_REFILL_CWF_EN
    assign w_start_word = req_paddr[4:2];
    assign w_unused     = ^req_vaddr[4:2];
`else
    assign w_start_word = 3'd0;
    assign w_unused     = ^{req_vaddr[4:2], req_paddr[4:2]};
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_line_vaddr    <= '0;
            r_line_paddr    <= '0;
            r_word_idx      <= '0;
            r_beat_cnt      <= '0;
            // NOTE: the line buffer is cleared on reset because it is visible on cache_port_data.
            r_line_data     <= '0;
            r_req_ready     <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_in_write      <= 1'b0;
            r_in_fault      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && !abort) begin
                        r_line_vaddr    <= req_vaddr[`VLEN-1:5];
                        r_line_paddr    <= req_paddr[`XLEN-1:5];
                        r_word_idx      <= w_start_word;
                        r_beat_cnt      <= '0;
                        r_state         <= S_ISSUE;
                        r_req_ready     <= 1'b0;
                        r_mem_req_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // An accepted request always owes us a response, even when aborted.
                    if (abort) begin
                        r_mem_req_valid <= 1'b0;
                        if (mem_req_ready) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                        end
                    end else if (mem_req_ready) begin
                        r_state         <= S_WAIT;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        if (mem_resp_valid) begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (mem_resp_valid) begin
                        if (mem_resp_error) begin
                            r_state    <= S_FAULT;
                            r_in_fault <= 1'b1;
                        end else begin
                            r_line_data[r_word_idx] <= mem_resp_data;
                            r_word_idx              <= r_word_idx + 3'd1;
                            r_beat_cnt              <= r_beat_cnt + 4'd1;
                            if (r_beat_cnt == 4'd7) begin
                                r_state    <= S_WRITE;
                                r_in_write <= 1'b1;
                            end else begin
                                r_state         <= S_ISSUE;
                                r_mem_req_valid <= 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (abort || !stall) begin
                        r_state     <= S_IDLE;
                        r_in_write  <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                S_FAULT: begin
                    r_state     <= S_IDLE;
                    r_in_fault  <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                S_DRAIN: begin
                    if (mem_resp_valid) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_req_ready     <= 1'b1;
                    r_mem_req_valid <= 1'b0;
                    r_in_write      <= 1'b0;
                    r_in_fault      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready       = r_req_ready;
    assign mem_req_valid   = r_mem_req_valid;
    assign mem_req_addr    = {r_line_paddr, r_word_idx};
    assign cache_port_addr = r_line_vaddr;
    assign cache_port_data = r_line_data;

    // Abort must suppress the write and completion in the same cycle it is raised.
    assign cache_port_set  = r_in_write & ~abort;
    assign done            = (r_in_write & ~stall & ~abort) | (r_in_fault & ~abort);
    assign fault           = r_in_fault & ~abort;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit with a zero-wait memory model and
// scoreboards for beat addresses and completed lines.
`ifndef VLEN
`define VLEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_icache_refill_unit;

    typedef logic [`VLEN-1:2] vaddr_t;
    typedef logic [`XLEN-1:2] paddr_t;
    typedef struct {
        logic [`VLEN-1:5] vline;
        logic [255:0]     data;
    } line_t;

`ifdef ICACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic                clock;
    logic                reset_n;
    logic                req_valid;
    logic                req_ready;
    vaddr_t              req_vaddr;
    paddr_t              req_paddr;
    logic                abort;
    logic                stall;
    logic                mem_req_valid;
    logic                mem_req_ready;
    paddr_t              mem_req_addr;
    logic                mem_resp_valid;
    logic [31:0]         mem_resp_data;
    logic                mem_resp_error;
    logic [`VLEN-1:5]    cache_port_addr;
    logic [7:0][31:0]    cache_port_data;
    logic                cache_port_set;
    logic                done;
    logic                fault;

    icache_refill_unit dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_vaddr       (req_vaddr),
        .req_paddr       (req_paddr),
        .abort           (abort),
        .stall           (stall),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .mem_resp_error  (mem_resp_error),
        .cache_port_addr (cache_port_addr),
        .cache_port_data (cache_port_data),
        .cache_port_set  (cache_port_set),
        .done            (done),
        .fault           (fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int     n_compared   = 0;
    int     n_mismatched = 0;
    paddr_t exp_addr_q[$];
    line_t  exp_line_q[$];

    int     mem_lat   = 0;
    int     err_beat  = -1;
    int     mem_beat  = 0;
    int     resp_wait = -1;
    bit     resp_err  = 1'b0;
    bit     spur_req  = 1'b0;
    paddr_t resp_addr;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory contents: odd-multiplier hash, so every word address holds a distinct value.
    function automatic logic [31:0] mem_word(input paddr_t a);
        logic [31:0] w;
        w = 32'(a);
        return (w * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    // Word-addressed memory, one response per accepted request after mem_lat extra cycles.
    initial begin
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mem_resp_error = 1'b0;
        forever begin
            @(negedge clock);
            mem_resp_valid = 1'b0;
            mem_resp_error = 1'b0;
            if (!reset_n) begin
                resp_wait = -1;
            end else if (resp_wait == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_error = resp_err;
                mem_resp_data  = resp_err ? 32'hDEAD_BEEF : mem_word(resp_addr);
                resp_wait      = -1;
            end else if (resp_wait > 0) begin
                resp_wait--;
            end else if (spur_req) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'h5555_AAAA;
                spur_req       = 1'b0;
            end
            if (reset_n && mem_req_valid && mem_req_ready) begin
                check("one_outstanding", resp_wait == -1, 1'b1);
                check("mem_req_expected", exp_addr_q.size() != 0, 1'b1);
                if (exp_addr_q.size() != 0)
                    check("mem_req_addr", mem_req_addr, exp_addr_q.pop_front());
                resp_addr = mem_req_addr;
                resp_err  = (mem_beat == err_beat);
                mem_beat++;
                resp_wait = mem_lat;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_req(input vaddr_t va, input paddr_t pa, input bit push_line);
        logic [2:0]   s;
        logic [255:0] line;
        line_t        e;
        s = CWF ? pa[4:2] : 3'd0;
        exp_addr_q.delete();
        for (int k = 0; k < 8; k++)
            exp_addr_q.push_back({pa[`XLEN-1:5], 3'(s + 3'(k))});
        for (int i = 0; i < 8; i++)
            line[i*32 +: 32] = mem_word({pa[`XLEN-1:5], 3'(i)});
        e.vline = va[`VLEN-1:5];
        e.data  = line;
        if (push_line) exp_line_q.push_back(e);
        mem_beat = 0;
        @(negedge clock);
        check("req_ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1;
        req_vaddr = va;
        req_paddr = pa;
        @(negedge clock);
        req_valid = 1'b0;
        #1;
    endtask

    task automatic wait_set(output int edges);
        edges = 1;
        while (!cache_port_set && edges < 200) begin
            @(negedge clock);
            #1;
            edges++;
        end
        check("write_reached_in_budget", edges < 200, 1'b1);
    endtask

    task automatic check_line();
        line_t e;
        check("line_expected", exp_line_q.size() != 0, 1'b1);
        if (exp_line_q.size() != 0) begin
            e = exp_line_q.pop_front();
            check("line_addr", cache_port_addr, e.vline);
            check("line_data", cache_port_data, e.data);
        end
    endtask

    initial begin
        int edges;
        int n_set;
        bit seen;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_vaddr = '0;
        req_paddr = '0;
        abort     = 1'b0;
        stall     = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_set", cache_port_set, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_addr", cache_port_addr, '0);
        check("rst_data", cache_port_data, '0);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("rst_req_ready", req_ready, 1'b1);

        // Zero-wait refill, missed word 5
        start_req(vaddr_t'(32'h0123_4567), paddr_t'(32'h0001_2345), 1'b1);
        wait_set(edges);
        check("latency_17", edges, 17);
        check_line();
        check("done_with_set", done, 1'b1);
        check("no_fault_ok", fault, 1'b0);
        check("all_beats_issued", exp_addr_q.size(), 0);
        @(negedge clock);
        #1;
        check("set_one_cycle", cache_port_set, 1'b0);
        check("done_one_cycle", done, 1'b0);
        check("ready_after_done", req_ready, 1'b1);

        // Response in IDLE is ignored, abort with req_valid blocks acceptance
        spur_req = 1'b1;
        repeat (3) begin
            @(negedge clock);
            #1;
            check("idle_resp_ready", req_ready, 1'b1);
            check("idle_resp_no_req", mem_req_valid, 1'b0);
            check("idle_resp_no_done", done | cache_port_set, 1'b0);
        end
        @(negedge clock);
        req_valid = 1'b1;
        abort     = 1'b1;
        req_vaddr = vaddr_t'(32'h0000_1000);
        req_paddr = paddr_t'(32'h0000_2000);
        @(negedge clock);
        req_valid = 1'b0;
        abort     = 1'b0;
        #1;
        check("abort_blocks_req_ready", req_ready, 1'b1);
        check("abort_blocks_req_issue", mem_req_valid, 1'b0);

        // Stall held three cycles on WRITE entry
        stall = 1'b1;
        start_req(vaddr_t'(32'h0ABC_0000), paddr_t'(32'h0002_0008), 1'b1);
        wait_set(edges);
        for (int c = 0; c < 3; c++) begin
            check("stall_set_held", cache_port_set, 1'b1);
            check("stall_no_done", done, 1'b0);
            check("stall_data_stable", cache_port_data, exp_line_q[0].data);
            @(negedge clock);
            if (c == 2) stall = 1'b0;
            #1;
        end
        check("stall_set_4th", cache_port_set, 1'b1);
        check("stall_done_4th", done, 1'b1);
        check_line();
        @(negedge clock);
        #1;
        check("stall_set_drop", cache_port_set, 1'b0);
        check("stall_done_once", done, 1'b0);

        // Bus error on beat index 3
        err_beat = 3;
        start_req(vaddr_t'(32'h0111_1110), paddr_t'(32'h0003_0003), 1'b0);
        n_set = 0;
        seen  = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (cache_port_set) n_set++;
            if (done) begin
                check("fault_with_done", fault, 1'b1);
                seen = 1'b1;
            end
            @(negedge clock);
            #1;
        end
        check("fault_seen", seen, 1'b1);
        check("fault_no_set", n_set, 0);
        check("fault_beats", mem_beat, 4);
        check("fault_ready_next", req_ready, 1'b1);
        check("fault_one_cycle", done | fault, 1'b0);
        err_beat = -1;
        exp_addr_q.delete();

        // Abort coincident with a response returns straight to IDLE
        start_req(vaddr_t'(32'h0222_2220), paddr_t'(32'h0004_0000), 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (mem_resp_valid) seen = 1'b1;
            else begin
                @(negedge clock);
                #1;
            end
        end
        check("coinc_resp_seen", seen, 1'b1);
        abort = 1'b1;
        exp_addr_q.delete();
        @(negedge clock);
        abort = 1'b0;
        #1;
        check("coinc_abort_idle", req_ready, 1'b1);
        check("coinc_abort_no_req", mem_req_valid, 1'b0);
        repeat (2) begin
            @(negedge clock);
            #1;
            check("coinc_stays_idle", mem_req_valid | cache_port_set | done, 1'b0);
        end

        // Abort in WAIT before the response: drain then IDLE
        mem_lat = 4;
        start_req(vaddr_t'(32'h0333_3330), paddr_t'(32'h0005_0004), 1'b0);
        @(negedge clock);
        check("drain_in_wait", mem_req_valid, 1'b0);
        abort = 1'b1;
        exp_addr_q.delete();
        @(negedge clock);
        abort = 1'b0;
        #1;
        check("drain_entered", req_ready, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            check("drain_no_done", done | cache_port_set, 1'b0);
            if (mem_resp_valid) begin
                check("drain_busy_at_resp", req_ready, 1'b0);
                seen = 1'b1;
            end
            @(negedge clock);
            #1;
        end
        check("drain_resp_seen", seen, 1'b1);
        check("drain_back_idle", req_ready, 1'b1);
        mem_lat = 0;
        start_req(vaddr_t'(32'h0444_4440), paddr_t'(32'h0006_0006), 1'b1);
        wait_set(edges);
        check("post_drain_latency", edges, 17);
        check_line();

        // Reset during beat index 4
        @(negedge clock);
        start_req(vaddr_t'(32'h0555_5550), paddr_t'(32'h0007_0001), 1'b0);
        for (int c = 0; c < 40 && mem_beat < 5; c++) begin
            @(negedge clock);
            #1;
        end
        check("reset_beat4_reached", mem_beat, 5);
        reset_n = 1'b0;
        exp_addr_q.delete();
        @(negedge clock);
        #1;
        check("midrst_mem_req_valid", mem_req_valid, 1'b0);
        check("midrst_set", cache_port_set, 1'b0);
        check("midrst_done_fault", done | fault, 1'b0);
        check("midrst_addr", cache_port_addr, '0);
        check("midrst_data", cache_port_data, '0);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("midrst_ready", req_ready, 1'b1);
        start_req(vaddr_t'(32'h0666_6660), paddr_t'(32'h0008_0007), 1'b1);
        wait_set(edges);
        check("post_rst_latency", edges, 17);
        check_line();
        check("post_rst_done", done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/icache_refill_unit.md
ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 clock  in  1  sole clock; all state updates on posedge.
REQ-002 reset_n  in  1  synchronous, active-low reset.
REQ-003 req_valid  in  1  refill request from execute stage on I-cache miss.
REQ-004 req_ready  out  1  high only in IDLE.
REQ-005 req_vaddr  in  [`VLEN-1:2]  virtual word address of missed instruction; tags the line.
REQ-006 req_paddr  in  [`XLEN-1:2]  translated physical word address.
REQ-007 abort  in  1  cancel refill (redirect or invalidate); no cache write may follow.
REQ-008 stall  in  1  pipeline stall; cache writes take effect only when low.
REQ-009 mem_req_valid / mem_req_ready  out / in  1 / 1  single-word read request handshake.
REQ-010 mem_req_addr  out  [`XLEN-1:2]  physical word address of current beat.
REQ-011 mem_resp_valid  in  1  response beat; mem_resp_data in 32; mem_resp_error in 1.
REQ-012 cache_port_addr  out  [`VLEN-1:5]  line address driven to fetch-stage cache port.
REQ-013 cache_port_data  out  [7:0][31:0]  assembled line, word i at index i.
REQ-014 cache_port_set  out  1  line write strobe.
REQ-015 done  out  1  one-cycle pulse at refill completion; fault out 1 pulses with done on bus error.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT, WRITE, FAULT, DRAIN.
REQ-017 IDLE: on req_valid, latch req_vaddr[`VLEN-1:5], req_paddr line base and start word; beat count=0; go ISSUE.
REQ-018 ISSUE: mem_req_valid=1, mem_req_addr={line base, beat word index}; on mem_req_ready go WAIT.
REQ-019 At most one memory request SHALL be outstanding.
REQ-020 WAIT: on mem_resp_valid with error=0, store data at current word index, increment count; count reaching 8 -> WRITE, else ISSUE.
REQ-021 Word index SHALL wrap modulo 8 within the line (3-bit arithmetic); never crosses line boundary.
REQ-022 mem_resp_valid with error=1 -> FAULT; FAULT pulses done=1, fault=1 for one cycle, no cache_port_set, then IDLE.
REQ-023 WRITE: cache_port_set = !abort; held across stall cycles; first cycle with stall=0 and abort=0 pulses done=1 and returns IDLE.
REQ-024 Minimum latency, zero-wait memory: req accept to cache_port_set = 1 + 8x2 cycles (17).
REQ-025 abort in ISSUE without mem_req_ready, or in WRITE/FAULT: next state IDLE, no done/fault.
REQ-026 abort in WAIT, or in ISSUE with mem_req_ready high same cycle: go DRAIN; DRAIN discards one response then IDLE.
REQ-027 abort in WAIT coincident with mem_resp_valid: response discarded, next state IDLE directly.
REQ-028 abort in IDLE SHALL be ignored; req_valid and abort together in IDLE: request not accepted.
REQ-029 Memory responses arriving in IDLE SHALL be ignored.
REQ-030 cache_port_addr/data SHALL be stable from entry to WRITE until leaving it.

Reset
REQ-031 reset_n low SHALL force IDLE, count 0, and outputs: req_ready=1 after release, mem_req_valid=0, cache_port_set=0, done=0, fault=0, cache_port_addr=0, cache_port_data=0.
REQ-032 Reset mid-refill SHALL abandon the refill without drain; system reset of memory is concurrent.

Configuration
REQ-033 ICACHE_REFILL_CWF_EN defined: first beat at missed word req_paddr[4:2], then wrapping upward (critical word first).
REQ-034 ICACHE_REFILL_CWF_EN undefined: beats always start at word 0 and run 0..7; req_paddr[4:2] ignored.

Verification
REQ-035 Zero-wait memory, req_paddr word 5, CWF_EN on -> addresses words 5,6,7,0,1,2,3,4; set at cycle 17; data[i]=memory word i.
REQ-036 Same with CWF_EN off -> addresses words 0..7 in order; identical line contents.
REQ-037 stall=1 for 3 cycles on WRITE entry -> cache_port_set high 4 cycles, data stable, done once on 4th.
REQ-038 mem_resp_error=1 on beat 3 -> done=fault=1 one cycle, no cache_port_set, req_ready high next cycle.
REQ-039 abort in WAIT before response -> DRAIN; late response dropped; new request afterwards completes with correct data.
REQ-040 reset_n low during beat 4 -> all outputs reset next cycle; fresh request completes normally.
